// File: rtl/jk_bank_arbiter.sv
// Arbitrated J/K pulse driver for a bank of JK bits with a post-pulse settle window.
// Define JK_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module jk_bank_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         cmd,
  input  logic [WIDTH*N_REQ-1:0]     mask,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           j,
  output logic [WIDTH-1:0]           k,
  output logic [WIDTH-1:0]           q,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSettle,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  bank_q, bank_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;

  // (base + off) mod N_REQ; off never exceeds N_REQ-1 so one subtraction suffices.
  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end
    return IdxW'(s);
  endfunction

  // First asserted request scanning upward from the pointer; in fixed-priority
  // mode the pointer is pinned at 0 so the same scan yields lowest-index-wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = wrap_idx(ptr_q, i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    j       = '0;
    k       = '0;
    gnt     = '0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          owner_d = win_idx;
          cmd_d   = cmd[2*win_idx +: 2];
          mask_d  = mask[WIDTH*win_idx +: WIDTH];
          state_d = StApply;
        end
      end
      StApply: begin
        j       = mask_q & {WIDTH{cmd_q[1]}};
        k       = mask_q & {WIDTH{cmd_q[0]}};
        // JK characteristic; unmasked bits see j=k=0 and hold.
        bank_d  = (j & ~bank_q) | (~k & bank_q);
        cnt_d   = SettleLoad;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        gnt[owner_q] = 1'b1;
`ifdef JK_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = wrap_idx(owner_q, 1);
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  assign q     = bank_q;
  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

endmodule
